// File: rtl/uart_multibyte_transmitter.sv
// Multibyte 8N1 UART transmitter: one 2**MSG_LOG_WIDTH-byte word per valid/ready handshake, byte 0 first.
// Define UART_MB_TX_TWO_STOP_EN to end every byte with two stop bits (11-bit frames).
module uart_multibyte_transmitter #(
  parameter int CLK_CYCLES    = 4178,
  parameter int CTR_WIDTH     = 16,
  parameter int MSG_LOG_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [8*(2**MSG_LOG_WIDTH)-1:0]   data,
  input  logic                              valid,
  output logic                              ready,
  output logic                              uart_tx,
  output logic [7:0]                        led
);

  localparam int NUM_BYTES = 2**MSG_LOG_WIDTH;
  localparam int MSG_W     = 8*NUM_BYTES;
  localparam int BIDX_W    = (MSG_LOG_WIDTH > 0) ? MSG_LOG_WIDTH : 1;
`ifdef UART_MB_TX_TWO_STOP_EN
  localparam logic [2:0] LAST_STOP = 3'd1;
`else
  localparam logic [2:0] LAST_STOP = 3'd0;
`endif
  localparam logic [CTR_WIDTH-1:0] BIT_LOAD  = CTR_WIDTH'(CLK_CYCLES-1);
  localparam logic [BIDX_W-1:0]    LAST_BYTE = BIDX_W'(NUM_BYTES-1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_d;
  logic [CTR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [BIDX_W-1:0]     byte_q, byte_d;
  logic [MSG_W-1:0]      msg_q, msg_d;
  logic [7:0]            led_q, led_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic [7:0]            next_byte;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      msg_q   <= '0;
      led_q   <= 8'h00;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      msg_q   <= msg_d;
      led_q   <= led_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    msg_d   = msg_q;
    led_d   = led_q;
    case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          msg_d   = data;
          byte_d  = '0;
          bit_d   = '0;
          cnt_d   = BIT_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = BIT_LOAD;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LOAD;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LOAD;
          if (bit_q == LAST_STOP) begin
            // Byte done: publish it, drop it from the buffer, move to the next one.
            bit_d   = '0;
            led_d   = msg_q[7:0];
            msg_d   = msg_q >> 8;
            if (byte_q == LAST_BYTE) begin
              byte_d  = '0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              byte_d  = byte_q + 1'b1;
              state_d = START;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line never glitches.
  assign next_byte = msg_d[7:0];

  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    case (state_d)
      IDLE:    ready_d = 1'b1;
      START:   tx_d    = 1'b0;
      DATA:    tx_d    = next_byte[bit_d];
      default: tx_d    = 1'b1;
    endcase
  end

  assign ready   = ready_q;
  assign uart_tx = tx_q;
  assign led     = led_q;

endmodule
